fir_decimator: RTL and testbench
================================

Name: fir_decimator

Overview:
- Downstream stage of the FIR low-pass filter: takes the filtered sample stream and decimates it by a power-of-two ratio.
- Decimation is integrate-and-dump: each group of DECIM accepted samples produces one averaged, rounded output.
- Results are buffered in a small output FIFO with a valid/ready handshake, so a slow consumer does not stall the filter.
- The filter side has no backpressure; when the FIFO is full, results are dropped and flagged.

Parameters:
- DATA_WIDTH, 16, signed sample width for input and output.
- DECIM, 4, decimation ratio. Power of two, 2..256. A non-power-of-two value is an elaboration error.
- FIFO_DEPTH, 4, output FIFO entries. Power of two, 2..64.

Ports:
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous clear of accumulator, phase, FIFO and overflow flag.
- in_valid, in, 1, in_data is a valid filter output this cycle.
- in_data, in, DATA_WIDTH, signed filter output sample.
- out_valid, out, 1, FIFO head is valid.
- out_ready, in, 1, consumer accepts head this cycle.
- out_data, out, DATA_WIDTH, signed decimated sample at FIFO head.
- fifo_level, out, $clog2(FIFO_DEPTH)+1, number of occupied entries.
- overflow, out, 1, sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous): clears accumulator, phase counter, FIFO pointers and overflow. out_valid=0, out_data=0, fifo_level=0, overflow=0.
- Accumulator width: DATA_WIDTH+log2(DECIM), signed, so it never overflows.
- Phase counter (0..DECIM-1) advances only on cycles with in_valid=1. Gaps hold both phase and accumulator.
- On in_valid with phase<DECIM-1: acc <= acc + in_data; phase++.
- On in_valid with phase=DECIM-1:
  - result = (acc + in_data + DECIM/2) >>> log2(DECIM), an arithmetic shift (round half up). It is truncated to DATA_WIDTH, which is always in range.
  - acc <= 0; phase <= 0; result pushed to the FIFO on the same edge.
- Latency: the result is written on the edge that accepts the DECIM-th sample. out_valid and out_data reflect it after that edge when the FIFO was empty (1-cycle latency, no combinational in-to-out path).
- Pop: occurs on an edge where out_valid && out_ready. The head advances; out_data shows the next entry, or 0 when empty.
- out_data is held stable while out_valid=1 and out_ready=0.
- Push when not full: entry stored in order.
- Push when full:
  - Without a same-cycle pop: result dropped, overflow <= 1, FIFO unchanged.
  - With a same-cycle pop: push accepted, level unchanged, no overflow.
- Simultaneous push and pop with FIFO empty: no pop occurs (out_valid=0), push stored, level becomes 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH; full is level==FIFO_DEPTH.
- flush=1: on the next edge, clears acc, phase, FIFO and overflow, and ignores that cycle's in_valid and out_ready. flush has priority over all other events.
- overflow stays set until reset or flush.
- Reset asserted mid-group: the partial sum is discarded; the first group after release starts at phase 0.

Test Plan (DECIM=4, FIFO_DEPTH=4, DATA_WIDTH=16):
1. Reset check: hold reset=0 for 2 cycles with in_valid=1 and in_data=100 -> out_valid=0, out_data=0, fifo_level=0, overflow=0; after release, nothing is pushed until the 4th accepted sample.
2. Ramp: in_data 1..8 continuous, out_ready=1 -> outputs 3 ((10+2)>>2) and 7 ((26+2)>>2). Each appears one cycle after its 4th input.
3. Rounding and extremes:
   - -1,-1,-1,-2 -> -1.
   - 32767 x4 -> 32767.
   - -32768 x4 -> -32768.
   - 1,1,0,0 -> 1 (2/4 = 0.5 rounds up).
4. Gapped input: four samples 4,4,4,4 with in_valid idle for 3 cycles between each -> single output 4; phase is not advanced during gaps.
5. Backpressure/overflow:
   - out_ready=0, feed 24 samples of value 5*k per group (k=1..6) -> fifo_level=4; overflow=1 after the 5th result; results 5 and 6 lost.
   - Then out_ready=1 -> drains 5,10,15,20 in order, out_valid low afterwards.
6. Full with concurrent pop: FIFO full, out_ready=1 on the cycle the 5th result completes -> level stays 4, overflow=0.
   - Then flush=1 for one cycle -> level=0, out_valid=0, overflow=0.
   - Mid-group reset: the next group outputs exactly the average of 4 new samples.

Source files
------------

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator with a rounded average per group of DECIM samples,
// buffered in a small output FIFO with a valid/ready handshake and a sticky drop flag.
module fir_decimator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  input  logic [DATA_WIDTH-1:0]         in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o
);

  localparam int unsigned ShW  = $clog2(DECIM);
  localparam int unsigned AccW = DATA_WIDTH + ShW;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  if (DECIM < 2 || DECIM > 256 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
    $error("DECIM must be a power of two in 2..256");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..64");
  end

  logic [AccW-1:0]       acc_q, acc_d;
  logic [ShW-1:0]        phase_q, phase_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AccW-1:0]       in_ext, acc_sum, rnd_sum;
  logic [DATA_WIDTH-1:0] result;
  logic                  last_phase, push_req, push, pop, full;
  logic                  unused_rnd_bits;

  // The full group sum plus the rounding term always fits in AccW bits.
  always_comb begin
    in_ext     = {{ShW{in_data_i[DATA_WIDTH-1]}}, in_data_i};
    acc_sum    = acc_q + in_ext;
    rnd_sum    = acc_sum + AccW'(DECIM / 2);
    result     = rnd_sum[AccW-1:ShW];
    last_phase = (phase_q == ShW'(DECIM - 1));
  end

  assign unused_rnd_bits = ^rnd_sum[ShW-1:0];

  always_comb begin
    full     = (level_q == LvlW'(FIFO_DEPTH));
    push_req = in_valid_i && last_phase && !flush_i;
    pop      = out_valid_o && out_ready_i && !flush_i;
    push     = push_req && (!full || pop);

    acc_d      = acc_q;
    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (flush_i) begin
      acc_d      = '0;
      phase_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (in_valid_i) begin
        if (last_phase) begin
          acc_d   = '0;
          phase_d = '0;
        end else begin
          acc_d   = acc_sum;
          phase_d = phase_q + ShW'(1);
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        level_d = level_q + LvlW'(1);
      end else if (pop && !push) begin
        level_d = level_q - LvlW'(1);
      end
      if (push_req && !push) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q      <= '0;
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: an entry is only visible once the level covers it.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= result;
  end

  assign out_valid_o  = (level_q != '0);
  assign out_data_o   = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_level_o = level_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed vector bench for fir_decimator (DECIM=4, FIFO_DEPTH=4, DATA_WIDTH=16).
module tb_fir_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  fifo_level;
  logic        overflow;

  int vec_count = 0;
  int err_count = 0;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] id;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  el;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  fir_decimator #(
    .DATA_WIDTH(16),
    .DECIM     (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .fifo_level_o(fifo_level),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic fl, input logic iv, input int id, input logic rdy,
                              input logic ev, input int ed, input int el, input logic eo);
    vec_t r;
    r.fl  = fl;
    r.iv  = iv;
    r.id  = 16'(id);
    r.rdy = rdy;
    r.ev  = ev;
    r.ed  = 16'(ed);
    r.el  = 3'(el);
    r.eo  = eo;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic ev, input logic [15:0] ed,
                       input logic [2:0] el, input logic eo);
    vec_count++;
    if (out_valid !== ev || out_data !== ed || fifo_level !== el || overflow !== eo) begin
      err_count++;
      $display("FAIL %s: got valid=%0b data=%0d level=%0d ovf=%0b, want valid=%0b data=%0d level=%0d ovf=%0b",
               name, out_valid, $signed(out_data), fifo_level, overflow,
               ev, $signed(ed), el, eo);
    end
  endtask

  task automatic apply(input string name, input vec_t r);
    flush     = r.fl;
    in_valid  = r.iv;
    in_data   = r.id;
    out_ready = r.rdy;
    @(posedge clk);
    #1;
    check(name, r.ev, r.ed, r.el, r.eo);
  endtask

  initial begin
    int el;
    logic ev;
    logic eo;
    int ed;

    // Ramp 1..8 with an always-ready consumer.
    for (int i = 1; i <= 8; i++) begin
      if (i == 4)      add(0, 1, i, 1, 1, 3, 1, 0);
      else if (i == 8) add(0, 1, i, 1, 1, 7, 1, 0);
      else             add(0, 1, i, 1, 0, 0, 0, 0);
    end
    // Rounding and extremes; each group's first sample pops the previous result.
    add(0, 1, -1, 1, 0, 0, 0, 0);
    add(0, 1, -1, 1, 0, 0, 0, 0);
    add(0, 1, -1, 1, 0, 0, 0, 0);
    add(0, 1, -2, 1, 1, -1, 1, 0);
    for (int s = 0; s < 4; s++) add(0, 1, 32767, 1, s == 3, s == 3 ? 32767 : 0, s == 3 ? 1 : 0, 0);
    for (int s = 0; s < 4; s++) add(0, 1, -32768, 1, s == 3, s == 3 ? -32768 : 0, s == 3 ? 1 : 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Gapped input with junk data on idle cycles.
    for (int s = 0; s < 4; s++) begin
      add(0, 1, 4, 1, s == 3, s == 3 ? 4 : 0, s == 3 ? 1 : 0, 0);
      if (s < 3) for (int g = 0; g < 3; g++) add(0, 0, 999, 1, 0, 0, 0, 0);
    end
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Backpressure: six groups of 5k, FIFO fills after four, last two dropped.
    for (int k = 1; k <= 6; k++) begin
      for (int s = 0; s < 4; s++) begin
        ev = (k > 1) || (s == 3);
        ed = ev ? 5 : 0;
        el = (s == 3) ? ((k < 4) ? k : 4) : ((k - 1 < 4) ? k - 1 : 4);
        eo = (s == 3) ? (k >= 5) : (k >= 6);
        add(0, 1, 5 * k, 0, ev, ed, el, eo);
      end
    end
    add(0, 0, 0, 1, 1, 10, 3, 1);
    add(0, 0, 0, 1, 1, 15, 2, 1);
    add(0, 0, 0, 1, 1, 20, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    // Full FIFO with a pop on the same edge as the fifth push.
    for (int k = 1; k <= 4; k++) begin
      for (int s = 0; s < 4; s++) begin
        ev = (k > 1) || (s == 3);
        add(0, 1, 100 * k, 0, ev, ev ? 100 : 0, (s == 3) ? k : k - 1, 0);
      end
    end
    add(0, 1, 500, 0, 1, 100, 4, 0);
    add(0, 1, 500, 0, 1, 100, 4, 0);
    add(0, 1, 500, 0, 1, 100, 4, 0);
    add(0, 1, 500, 1, 1, 200, 4, 0);
    // Flush wins over in_valid and out_ready on the same cycle.
    add(1, 1, 7, 1, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) add(0, 1, 8, 0, s == 3, s == 3 ? 8 : 0, s == 3 ? 1 : 0, 0);
    add(0, 1, 1000, 0, 1, 8, 1, 0);
    add(0, 1, 1000, 0, 1, 8, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) add(0, 1, 12, 0, s == 3, s == 3 ? 12 : 0, s == 3 ? 1 : 0, 0);
    add(0, 1, 1000, 0, 1, 12, 1, 0);
    add(0, 1, 1000, 0, 1, 12, 1, 0);

    // Reset held with live input.
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'd100;
    out_ready = 1'b0;
    #2;
    check("reset_t0", 0, 16'd0, 3'd0, 0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_cyc%0d", c), 0, 16'd0, 3'd0, 0);
    end
    rst_n = 1'b1;

    foreach (vecs[i]) apply($sformatf("vec[%0d]", i), vecs[i]);

    // Mid-group asynchronous reset: partial sum of 2000 and queued 12 are discarded.
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_async", 0, 16'd0, 3'd0, 0);
    @(posedge clk);
    #1;
    check("midreset_held", 0, 16'd0, 3'd0, 0);
    #3;
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      vec_t r;
      r.fl  = 0;
      r.iv  = 1;
      r.id  = 16'hFFFA;
      r.rdy = 0;
      r.ev  = (s == 3);
      r.ed  = (s == 3) ? 16'hFFFA : 16'd0;
      r.el  = (s == 3) ? 3'd1 : 3'd0;
      r.eo  = 0;
      apply($sformatf("postreset[%0d]", s), r);
    end
    begin
      vec_t r;
      r.fl  = 0;
      r.iv  = 0;
      r.id  = 16'd0;
      r.rdy = 1;
      r.ev  = 0;
      r.ed  = 16'd0;
      r.el  = 3'd0;
      r.eo  = 0;
      apply("postreset_drain", r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
